tpu_c_drain: RTL
================

// Module: tpu_c_drain
// PURPOSE
//  Downstream of the TPU core: once a matmul finishes, reads result buffer C
//  (128-bit entries, 4 x int32 lanes) and streams the valid results as 32-bit
//  words over a valid/ready interface to the host or DMA. Drops padding lanes
//  when N is not a multiple of 4. One transfer per start pulse.
// PARAMETERS
//  ROW_W   128  C buffer entry width (4 lanes x WORD_W)
//  WORD_W  32   output word / lane width
//  IDX_W   16   C buffer index width
// PORTS
//  clk        in   1       clock; one clock domain, all logic on rising edge
//  rst        in   1       asynchronous, active-high reset
//  start_i    in   1       pulse: begin drain (sampled in IDLE only)
//  m_i        in   8       result rows M (sampled with start_i)
//  n_i        in   8       result cols N (sampled with start_i)
//  busy_o     out  1       high whenever FSM is not IDLE
//  done_o     out  1       1-cycle pulse after last word accepted
//  c_index_o  out  IDX_W   C buffer read address
//  c_data_i   in   ROW_W   C buffer read data, valid 1 cycle after c_index_o
//  out_valid  out  1       out_data holds a result word
//  out_ready  in   1       consumer accepts word when out_valid && out_ready
//  out_data   out  WORD_W  result word (int32, two's complement, unmodified)
//  out_row    out  8       row of out_data (0..M-1)
//  out_col    out  8       col of out_data (0..N-1)
//  out_last   out  1       high with the final word of the transfer
// BEHAVIOUR
//  Reset: one clock, asynchronous active-high reset (rst); FSM=IDLE;
//   busy_o, done_o, out_valid, out_last = 0; c_index_o, out_data, out_row,
//   out_col = 0. Reset mid-transfer abandons it, no done_o.
//  Layout: G = ceil(N/4) column groups; entry idx = grp*M + row, so idx runs
//   0..M*G-1 linearly. Lane 0 = c_data_i[127:96] (col grp*4), lane 3 = [31:0].
//   Lanes valid per entry: 4, except last group: ((N-1)%4)+1.
//   Word order: grp, then row, then lane.
//  FSM: IDLE -start_i-> READ (M=0 or N=0 -> DONE directly, no words).
//   READ: drive c_index_o=idx -> CAP.
//   CAP: latch c_data_i into shift reg, lane=0 -> EMIT.
//   EMIT: out_valid=1. On handshake: more valid lanes -> lane++, stay;
//    else last entry -> DONE; else idx++, row/grp advance -> READ.
//   DONE: done_o=1 for one cycle -> IDLE.
//  Latency: start_i in cycle t -> first out_valid in cycle t+3; each entry
//   costs 2 bubble cycles (READ, CAP) before its first word.
//  Handshake: out_valid never drops, and out_data/row/col/last stay stable,
//   while out_valid && !out_ready. out_ready is ignored when out_valid=0.
//  start_i outside IDLE is ignored; m_i/n_i changes after start are ignored.
//  Widths: idx max 255*64-1 = 16319 fits IDX_W; grp counter 7 bits.
//   c_index_o holds its last value outside READ.
// TESTING
//  1 M=2,N=4, C[0]={1,2,3,4},C[1]={5,6,7,8} -> words 1..8, rows 0,0,0,0,1,..,
//    cols 0..3 twice, out_last on 8, done_o one cycle after its handshake.
//  2 M=1,N=5, C[0]={10,11,12,13},C[1]={14,99,99,99} -> words 10..14 only,
//    col 4 on 14 with out_last; 99 never emitted.
//  3 Case 1 with out_ready toggled 1,0,0,1,... -> same 8 words in order,
//    outputs stable during stalls, no duplicates or drops.
//  4 start_i with M=0,N=7 -> out_valid never rises; done_o at t+2.
//  5 rst pulsed during EMIT of word 3 of case 1 -> all outputs 0 next cycle,
//    no done_o; new start_i then replays from word 1.
//  6 start_i re-pulsed while busy_o=1 with different m_i/n_i -> ignored,
//    original transfer completes unchanged.

Source files
------------

// File: rtl/tpu_c_drain.sv
// Drains result buffer C after a matmul: reads 4-lane int32 entries and streams
// the valid lanes as 32-bit words over valid/ready, dropping padding lanes.
module tpu_c_drain #(
   parameter int unsigned ROW_W  = 128,
   parameter int unsigned WORD_W = 32,
   parameter int unsigned IDX_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [7:0]        m_i,
   input  logic [7:0]        n_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [IDX_W-1:0]  c_index_o,
   input  logic [ROW_W-1:0]  c_data_i,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_data,
   output logic [7:0]        out_row,
   output logic [7:0]        out_col,
   output logic              out_last
);

   localparam int unsigned GRP_W  = 7;
   localparam int unsigned LANE_W = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_CAP,
      S_EMIT,
      S_DONE
   } state_t;

   state_t              r_state, w_state;
   logic [7:0]          r_m, w_m;
   logic [7:0]          r_n, w_n;
   logic [GRP_W-1:0]    r_g, w_g;
   logic [7:0]          r_row, w_row;
   logic [GRP_W-1:0]    r_grp, w_grp;
   logic [LANE_W-1:0]   r_lane, w_lane;
   logic [IDX_W-1:0]    r_idx, w_idx;
   logic [IDX_W-1:0]    r_c_index, w_c_index;
   logic [ROW_W-1:0]    r_shift, w_shift;
   logic [7:0]          r_col, w_col;
   logic                r_last, w_last;
   logic                r_valid, w_valid;
   logic                r_busy, w_busy;
   logic                r_done, w_done;

   logic                w_last_grp;
   logic                w_last_entry;
   logic [LANE_W-1:0]   w_lanes_m1;

   // Only the final column group can carry padding lanes.
   assign w_last_grp   = (r_grp == (r_g - GRP_W'(1)));
   assign w_last_entry = w_last_grp && (r_row == (r_m - 8'd1));
   assign w_lanes_m1   = w_last_grp ? LANE_W'(r_n - 8'd1) : LANE_W'(3);

   // State register and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_m       <= '0;
         r_n       <= '0;
         r_g       <= '0;
         r_row     <= '0;
         r_grp     <= '0;
         r_lane    <= '0;
         r_idx     <= '0;
         r_c_index <= '0;
         r_shift   <= '0;
         r_col     <= '0;
         r_last    <= 1'b0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_m       <= w_m;
         r_n       <= w_n;
         r_g       <= w_g;
         r_row     <= w_row;
         r_grp     <= w_grp;
         r_lane    <= w_lane;
         r_idx     <= w_idx;
         r_c_index <= w_c_index;
         r_shift   <= w_shift;
         r_col     <= w_col;
         r_last    <= w_last;
         r_valid   <= w_valid;
         r_busy    <= w_busy;
         r_done    <= w_done;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state   = r_state;
      w_m       = r_m;
      w_n       = r_n;
      w_g       = r_g;
      w_row     = r_row;
      w_grp     = r_grp;
      w_lane    = r_lane;
      w_idx     = r_idx;
      w_c_index = r_c_index;
      w_shift   = r_shift;
      w_col     = r_col;
      w_last    = r_last;

      unique case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_m       = m_i;
               w_n       = n_i;
               w_g       = GRP_W'((9'(n_i) + 9'd3) >> 2);
               w_row     = '0;
               w_grp     = '0;
               w_lane    = '0;
               w_idx     = '0;
               w_c_index = '0;
               w_state   = S_READ;
            end
         end
         S_READ: begin
            // Empty result matrices finish without emitting anything.
            if ((r_m == 8'd0) || (r_n == 8'd0)) begin
               w_state = S_DONE;
            end else begin
               w_state = S_CAP;
            end
         end
         S_CAP: begin
            w_shift = c_data_i;
            w_lane  = '0;
            w_col   = 8'({r_grp, 2'b00});
            w_last  = w_last_entry && (w_lanes_m1 == LANE_W'(0));
            w_state = S_EMIT;
         end
         S_EMIT: begin
            if (out_ready) begin
               if (r_lane != w_lanes_m1) begin
                  w_lane  = r_lane + LANE_W'(1);
                  w_shift = r_shift << WORD_W;
                  w_col   = r_col + 8'd1;
                  w_last  = w_last_entry && ((r_lane + LANE_W'(1)) == w_lanes_m1);
               end else if (w_last_entry) begin
                  w_last  = 1'b0;
                  w_state = S_DONE;
               end else begin
                  w_last = 1'b0;
                  if (r_row == (r_m - 8'd1)) begin
                     w_row = '0;
                     w_grp = r_grp + GRP_W'(1);
                  end else begin
                     w_row = r_row + 8'd1;
                  end
                  w_idx     = r_idx + IDX_W'(1);
                  w_c_index = r_idx + IDX_W'(1);
                  w_state   = S_READ;
               end
            end
         end
         S_DONE: begin
            w_state = S_IDLE;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase

      w_busy  = (w_state != S_IDLE);
      w_valid = (w_state == S_EMIT);
      w_done  = (w_state == S_DONE);
   end

   assign busy_o    = r_busy;
   assign done_o    = r_done;
   assign c_index_o = r_c_index;
   assign out_valid = r_valid;
   assign out_data  = r_shift[ROW_W-1 -: WORD_W];
   assign out_row   = r_row;
   assign out_col   = r_col;
   assign out_last  = r_last;

endmodule
